mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of EXE; consumes EXE's registered outputs (ALU result, destination register, store data, ALU control, read/write flags).
- Performs loads and stores against the data cache through a valid/ready request and valid response interface.
- Holds EXE and everything upstream with STALL_OUT while an access is outstanding.
- Registers the writeback result, which also drives the MEM->EXE bypass port.

Parameters:
- ADDR_W, 32, data-cache address width
- DATA_W, 32, word width; only 32 is supported

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset (one clock; sampled on posedge CLK)
- Instr1_IN  in  32  instruction from EXE (debug)
- Instr1_PC_IN  in  32  PC from EXE (debug)
- ALU_result1_IN  in  32  effective address for memory ops; result for all others
- WriteRegister1_IN  in  5  destination register
- MemWriteData1_IN  in  32  store data, already forwarded by EXE
- RegWrite1_IN  in  1  instruction writes a register
- ALU_Control1_IN  in  6  selects memory op size/sign (mem_pkg codes)
- MemRead1_IN  in  1  load
- MemWrite1_IN  in  1  store
- dreq_valid  out  1  cache request valid
- dreq_ready  in  1  cache accepts request
- dreq_we  out  1  1 = store
- dreq_addr  out  32  word address; bits [1:0] are always 0
- dreq_wdata  out  32  store data, replicated into the active lanes
- dreq_be  out  4  byte enables; be[3] = bits 31:24 (big-endian lane 0)
- dresp_valid  in  1  load data valid
- dresp_rdata  in  32  load word
- STALL_OUT  out  1  combinational; freezes EXE and upstream; inputs are held stable while high
- Instr1_OUT, Instr1_PC_OUT  out  32  debug to WB
- WriteData1_OUT  out  32  writeback data
- WriteRegister1_OUT  out  5  writeback register
- RegWrite1_OUT  out  1  writeback enable
- ALIGN_ERR_OUT  out  1  one-cycle pulse on a misaligned access
- BypassReg1_MEMEXE  out  5  equals WriteRegister1_OUT
- BypassData1_MEMEXE  out  32  equals WriteData1_OUT
- BypassValid1_MEMEXE  out  1  equals RegWrite1_OUT

Behaviour:
- Reset (RESET high at posedge):
  - every registered output goes to 0;
  - FSM returns to IDLE;
  - dreq_valid and STALL_OUT are 0 while RESET is high.
  - Reset mid-access abandons the access; a dresp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- Non-memory instruction (MemRead1_IN = MemWrite1_IN = 0): one-cycle pass-through.
  - WriteData1_OUT <= ALU_result1_IN; no stall.
- Alignment:
  - word ops need addr[1:0] = 0; half-word ops need addr[0] = 0.
  - A misaligned access issues no request, does not stall, registers ALIGN_ERR_OUT = 1 for one cycle and forces RegWrite1_OUT = 0.
- Aligned memory op in IDLE:
  - dreq_valid = 1 combinationally; dreq_addr = {addr[31:2], 2'b00}.
  - Not accepted (dreq_ready = 0): go to REQ. dreq_valid, addr, we, be and wdata stay stable until accepted.
  - Store accepted: the access completes in the accept cycle.
  - Load accepted: go to RESP.
- RESP:
  - STALL_OUT = 1 until dresp_valid.
  - In the dresp_valid cycle, STALL_OUT = 0, the extracted data is registered and the FSM returns to IDLE.
  - Minimum load latency: 2 cycles (accept, then response).
- STALL_OUT = memory op active AND NOT (store accepted this cycle OR load response this cycle).
- While stalled, the writeback registers load a bubble: RegWrite1_OUT = 0.
- Load extraction, big-endian (byte at addr[1:0] = 0 is bits 31:24):
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB: be = one-hot lane, data replicated ×4.
  - SH: be = 4'b1100 or 4'b0011, halfword replicated ×2.
  - SW: be = 4'b1111.
- Write to register 0 forces RegWrite1_OUT = 0 (and therefore the bypass valid).
- Unknown ALU_Control1_IN with MemRead1_IN or MemWrite1_IN set is treated as a word op.
- MemRead1_IN and MemWrite1_IN both set is treated as a store.

Decomposition:
- mem_pkg holds:
  - MEM_LW = 6'h23, MEM_LB = 6'h20, MEM_LBU = 6'h24, MEM_LH = 6'h21, MEM_LHU = 6'h25, MEM_SW = 6'h2B, MEM_SB = 6'h28, MEM_SH = 6'h29;
  - FSM state encodings.
- Sub-module mem_align: purely combinational. Computes byte enables, store-data replication, load extraction/extension and the misalign flag.
- mem_stage: FSM, stall logic and output registers.

Test Plan:
- ALU op (ALU_result1_IN = 0x0000_1234, reg 5, RegWrite = 1) -> next cycle: WriteData1_OUT = 0x1234, RegWrite1_OUT = 1, bypass reg 5 valid, no stall.
- LB at 0x103 with dreq_ready = 1 and dresp_rdata = 0x1122_3380 one cycle later -> STALL_OUT high 1 cycle; WriteData1_OUT = 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at 0x202, data 0xAAAA_BEEF, dreq_ready held low 3 cycles -> dreq_valid held 4 cycles with addr 0x200, be = 4'b0011, wdata = 0xBEEF_BEEF; STALL_OUT high 3 cycles; RegWrite1_OUT = 0.
- LW at 0x301 -> no dreq_valid, ALIGN_ERR_OUT = 1 for exactly 1 cycle, RegWrite1_OUT = 0, no stall.
- LW accepted, RESET asserted in RESP, dresp_valid arrives the next cycle -> all outputs 0, FSM in IDLE, response ignored.
- LW to register 0 with data 0xDEAD_BEEF -> RegWrite1_OUT = 0 and BypassValid1_MEMEXE = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the data-cache op codes carried on ALU_Control, the MEM FSM state
// encodings, the writeback payload layout and small decode helpers.
package mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BE_W     = WORD_W / 8;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CTRL_W   = 6;

    // Memory op codes on ALU_Control1_IN
    localparam logic [CTRL_W-1:0] MEM_LW  = 6'h23;
    localparam logic [CTRL_W-1:0] MEM_LB  = 6'h20;
    localparam logic [CTRL_W-1:0] MEM_LBU = 6'h24;
    localparam logic [CTRL_W-1:0] MEM_LH  = 6'h21;
    localparam logic [CTRL_W-1:0] MEM_LHU = 6'h25;
    localparam logic [CTRL_W-1:0] MEM_SW  = 6'h2B;
    localparam logic [CTRL_W-1:0] MEM_SB  = 6'h28;
    localparam logic [CTRL_W-1:0] MEM_SH  = 6'h29;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Writeback payload handed to WB (and mirrored on the bypass port)
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] data;
        logic [REG_W-1:0]  wreg;
        logic              we;
    } wb_t;

    // Access size; any code that is not a byte/half op is treated as a word
    function automatic mem_size_e mem_size(input logic [CTRL_W-1:0] ctrl);
        mem_size_e sz;
        case (ctrl)
            MEM_LB, MEM_LBU, MEM_SB: sz = SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: sz = SZ_HALF;
            default:                 sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Loads that zero-extend instead of sign-extend
    function automatic logic mem_unsigned(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == MEM_LBU) || (ctrl == MEM_LHU);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage (big-endian: offset 0 = bits 31:24).
// Ports:
//   alu_ctrl    - op code selecting size and sign of the access
//   offset      - low two address bits
//   store_data  - store data from EXE (low lanes meaningful)
//   load_data   - word returned by the data cache
//   byte_en_c   - byte enables, bit 3 = bits 31:24
//   store_rep_c - store data replicated into every lane of its size
//   load_ext_c  - extracted and sign/zero-extended load value
//   misalign_c  - access not aligned to its size
module mem_align
    import mem_pkg::*;
(
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] load_data,
    output logic [BE_W-1:0]   byte_en_c,
    output logic [WORD_W-1:0] store_rep_c,
    output logic [WORD_W-1:0] load_ext_c,
    output logic              misalign_c
);

    mem_size_e size_c;
    logic      zext_c;
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;

    assign size_c = mem_size(alu_ctrl);
    assign zext_c = mem_unsigned(alu_ctrl);

    // Byte enables, store replication and alignment check
    always_comb begin
        byte_en_c   = 4'b1111;
        store_rep_c = store_data;
        misalign_c  = 1'b0;
        case (size_c)
            SZ_BYTE: begin
                byte_en_c   = 4'b1000 >> offset;
                store_rep_c = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en_c   = offset[1] ? 4'b0011 : 4'b1100;
                store_rep_c = {2{store_data[15:0]}};
                misalign_c  = offset[0];
            end
            default: begin
                misalign_c  = |offset;
            end
        endcase
    end

    // Lane selection for loads
    always_comb begin
        ld_byte_c = load_data[31:24];
        case (offset)
            2'd0:    ld_byte_c = load_data[31:24];
            2'd1:    ld_byte_c = load_data[23:16];
            2'd2:    ld_byte_c = load_data[15:8];
            default: ld_byte_c = load_data[7:0];
        endcase
        ld_half_c = offset[1] ? load_data[15:0] : load_data[31:16];
    end

    // Extension to a full word
    always_comb begin
        load_ext_c = load_data;
        case (size_c)
            SZ_BYTE: load_ext_c = zext_c ? {24'd0, ld_byte_c}
                                         : {{24{ld_byte_c[7]}}, ld_byte_c};
            SZ_HALF: load_ext_c = zext_c ? {16'd0, ld_half_c}
                                         : {{16{ld_half_c[15]}}, ld_half_c};
            default: load_ext_c = load_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to the data cache over a
// valid/ready request + valid response interface, stalls upstream while an
// access is outstanding and registers the writeback result (also the
// MEM->EXE bypass).
// Ports:
//   CLK, RESET              - clock, synchronous active-high reset
//   *1_IN                   - registered EXE outputs (held while STALL_OUT)
//   dreq_*                  - cache request (valid/ready), word address, BE, data
//   dresp_valid/rdata       - cache load response
//   STALL_OUT               - combinational upstream freeze
//   Instr1/PC/WriteData/WriteRegister/RegWrite1_OUT - registered writeback
//   ALIGN_ERR_OUT           - registered one-cycle misalign pulse
//   Bypass*_MEMEXE          - copies of the writeback registers
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instr1_IN,
    input  logic [31:0]       Instr1_PC_IN,
    input  logic [DATA_W-1:0] ALU_result1_IN,
    input  logic [4:0]        WriteRegister1_IN,
    input  logic [DATA_W-1:0] MemWriteData1_IN,
    input  logic              RegWrite1_IN,
    input  logic [5:0]        ALU_Control1_IN,
    input  logic              MemRead1_IN,
    input  logic              MemWrite1_IN,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_we,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [DATA_W-1:0] dreq_wdata,
    output logic [3:0]        dreq_be,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_rdata,
    output logic              STALL_OUT,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [DATA_W-1:0] WriteData1_OUT,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic              ALIGN_ERR_OUT,
    output logic [4:0]        BypassReg1_MEMEXE,
    output logic [DATA_W-1:0] BypassData1_MEMEXE,
    output logic              BypassValid1_MEMEXE
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr_full;
    logic              mem_op;
    logic              is_store;
    logic              access_ok;
    logic              req_c;
    logic              stall_c;
    logic              load_sel;
    logic              wb_we_c;
    logic [BE_W-1:0]   byte_en_c;
    logic [WORD_W-1:0] store_rep_c;
    logic [WORD_W-1:0] load_ext_c;
    logic              misalign_c;
    wb_t               wb_q;
    logic              align_err_q;

    // Both read and write set behaves as a store
    assign addr_full = ADDR_W'(ALU_result1_IN);
    assign mem_op    = MemRead1_IN | MemWrite1_IN;
    assign is_store  = MemWrite1_IN;
    assign access_ok = mem_op & ~misalign_c;
    assign load_sel  = access_ok & ~is_store;

    mem_align u_align (
        .alu_ctrl    (ALU_Control1_IN),
        .offset      (addr_full[1:0]),
        .store_data  (MemWriteData1_IN),
        .load_data   (dresp_rdata),
        .byte_en_c   (byte_en_c),
        .store_rep_c (store_rep_c),
        .load_ext_c  (load_ext_c),
        .misalign_c  (misalign_c)
    );

    // Request fields follow the held EXE inputs, so they stay stable in REQ
    assign dreq_we    = is_store;
    assign dreq_addr  = {addr_full[ADDR_W-1:2], 2'b00};
    assign dreq_wdata = store_rep_c;
    assign dreq_be    = byte_en_c;
    assign dreq_valid = req_c;
    assign STALL_OUT  = stall_c;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request valid and stall
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access_ok) begin
                    req_c = 1'b1;
                    if (!dreq_ready) begin
                        state_nxt = ST_REQ;
                        stall_c   = 1'b1;
                    end else if (!is_store) begin
                        state_nxt = ST_RESP;
                        stall_c   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dreq_ready) begin
                    if (is_store) begin
                        state_nxt = ST_IDLE;
                        stall_c   = 1'b0;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dresp_valid) begin
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (RESET) begin
            state_nxt = ST_IDLE;
            req_c     = 1'b0;
            stall_c   = 1'b0;
        end
    end

    // Stores and misaligned accesses never write a register; neither does r0
    assign wb_we_c = RegWrite1_IN & (|WriteRegister1_IN)
                   & ~(mem_op & (misalign_c | is_store));

    // Writeback registers; a bubble is loaded while stalled
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_q        <= '0;
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= mem_op & misalign_c;
            if (stall_c) begin
                wb_q <= '0;
            end else begin
                wb_q.instr <= Instr1_IN;
                wb_q.pc    <= Instr1_PC_IN;
                wb_q.data  <= load_sel ? load_ext_c : ALU_result1_IN;
                wb_q.wreg  <= WriteRegister1_IN;
                wb_q.we    <= wb_we_c;
            end
        end
    end

    assign Instr1_OUT          = wb_q.instr;
    assign Instr1_PC_OUT       = wb_q.pc;
    assign WriteData1_OUT      = wb_q.data;
    assign WriteRegister1_OUT  = wb_q.wreg;
    assign RegWrite1_OUT       = wb_q.we;
    assign ALIGN_ERR_OUT       = align_err_q;
    assign BypassReg1_MEMEXE   = wb_q.wreg;
    assign BypassData1_MEMEXE  = wb_q.data;
    assign BypassValid1_MEMEXE = wb_q.we;

endmodule
